// File: rtl/cfg_reg_pkg.sv
// rtl/cfg_reg_pkg.sv - shared types, address offsets and reset values for cfg_reg_bank
package cfg_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    function automatic int ctrl_ofs(input int num_ports);
        return num_ports;
    endfunction

    function automatic int version_ofs(input int num_ports);
        return num_ports + 1;
    endfunction

    localparam int   RST_REG_VAL = 0;
    localparam logic RST_ACK     = 1'b0;
    localparam logic RST_ERR     = 1'b0;

endpackage

// File: rtl/lat_counter.sv
// rtl/lat_counter.sv - loadable down-counter timing the WAIT phase of a request
module lat_counter #(
    parameter int CNT_W    = 1,
    parameter int LOAD_VAL = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(LOAD_VAL);
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // done marks the final WAIT cycle so the FSM can enter ACK on the next edge
    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/cfg_reg_bank.sv
// rtl/cfg_reg_bank.sv - per-port address registers, CTRL and VERSION behind a
// request/ack handshake with fixed ack latency
module cfg_reg_bank
    import cfg_reg_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter int                NUM_PORTS = 4,
    parameter int                ACK_LAT   = 1,
    parameter logic [DATA_W-1:0] VERSION   = 8'h01
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_sel_en,
    input  logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_wr_data,
    input  logic                        mem_wr_rd_s,
    output logic [DATA_W-1:0]           mem_rd_data,
    output logic                        mem_ack,
    output logic                        mem_err,
    output logic [NUM_PORTS*DATA_W-1:0] port_addr_o,
    output logic                        cfg_en_o,
    output logic                        busy_o
);

    localparam int CTRL_A = ctrl_ofs(NUM_PORTS);
    localparam int VER_A  = version_ofs(NUM_PORTS);
    localparam int CNT_W  = (ACK_LAT > 1) ? $clog2(ACK_LAT) : 1;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                wr_q;
    logic [DATA_W-1:0]   port_q [NUM_PORTS];
    logic [DATA_W-1:0]   ctrl_q;

    logic                accept;
    logic                cnt_done;
    logic                fire;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   op_data;
    logic                op_wr;
    logic [DATA_W-1:0]   rd_val;
    logic                mapped;
    logic                op_err;
    logic                wr_en;

    assign accept = (state_q == ST_IDLE) && mem_sel_en;

    lat_counter #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (ACK_LAT - 1)
    ) u_lat_counter (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .dec  (state_q == ST_WAIT),
        .done (cnt_done)
    );

    // With ACK_LAT=1 the operation executes on the accept edge, before capture
    always_comb begin
        op_addr = addr_q;
        op_data = data_q;
        op_wr   = wr_q;
        if (state_q == ST_IDLE) begin
            op_addr = mem_addr;
            op_data = mem_wr_data;
            op_wr   = mem_wr_rd_s;
        end
    end

    assign fire = (accept && (ACK_LAT == 1)) || ((state_q == ST_WAIT) && cnt_done);

    always_comb begin
        rd_val = '0;
        mapped = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (op_addr == ADDR_W'(i)) begin
                rd_val = port_q[i];
                mapped = 1'b1;
            end
        end
        if (op_addr == ADDR_W'(CTRL_A)) begin
            rd_val = ctrl_q;
            mapped = 1'b1;
        end
        if (op_addr == ADDR_W'(VER_A)) begin
            rd_val = VERSION;
            mapped = 1'b1;
        end
    end

    assign op_err = !mapped || (op_wr && (op_addr == ADDR_W'(VER_A)));
    assign wr_en  = fire && op_wr && !op_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                port_q[i] <= DATA_W'(RST_REG_VAL);
            end
            ctrl_q <= DATA_W'(RST_REG_VAL);
        end else if (wr_en) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (op_addr == ADDR_W'(i)) begin
                    port_q[i] <= op_data;
                end
            end
            if (op_addr == ADDR_W'(CTRL_A)) begin
                ctrl_q <= op_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            mem_ack     <= RST_ACK;
            mem_err     <= RST_ERR;
            mem_rd_data <= DATA_W'(RST_REG_VAL);
        end else begin
            mem_ack     <= 1'b0;
            mem_err     <= 1'b0;
            mem_rd_data <= '0;
            if (fire) begin
                mem_ack     <= 1'b1;
                mem_err     <= op_err;
                mem_rd_data <= (!op_wr && !op_err) ? rd_val : '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (mem_sel_en) begin
                        addr_q  <= mem_addr;
                        data_q  <= mem_wr_data;
                        wr_q    <= mem_wr_rd_s;
                        state_q <= (ACK_LAT == 1) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_done) begin
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // a request still held after its ack must not run again
                    if (!mem_sel_en) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_out
        assign port_addr_o[g*DATA_W +: DATA_W] = port_q[g];
    end

    assign cfg_en_o = ctrl_q[0];
    assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: doc/cfg_reg_bank.md
CFG_REG_BANK -- requirements
Module: cfg_reg_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning register and data-bus width.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning memory address width.
REQ-003 The block SHALL have parameter NUM_PORTS, default 4, meaning number of per-port address registers (1..2**ADDR_W-2).
REQ-004 The block SHALL have parameter ACK_LAT, default 1, meaning cycles from request accept to mem_ack (>=1).
REQ-005 The block SHALL have parameter VERSION, default 8'h01, meaning read-only version register value.
REQ-006 The block SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-008 The block SHALL have port mem_sel_en, input, 1, meaning request valid.
REQ-009 The block SHALL have port mem_addr, input, ADDR_W, meaning register address.
REQ-010 The block SHALL have port mem_wr_data, input, DATA_W, meaning write data.
REQ-011 The block SHALL have port mem_wr_rd_s, input, 1, meaning 1 = write, 0 = read.
REQ-012 The block SHALL have port mem_rd_data, output, DATA_W, meaning read data, valid with mem_ack.
REQ-013 The block SHALL have port mem_ack, output, 1, meaning one-cycle completion pulse.
REQ-014 The block SHALL have port mem_err, output, 1, meaning error flag, valid with mem_ack.
REQ-015 The block SHALL have port port_addr_o, output, NUM_PORTS*DATA_W, meaning port i register at bits [i*DATA_W +: DATA_W].
REQ-016 The block SHALL have port cfg_en_o, output, 1, meaning CTRL bit 0 (global switch enable).
REQ-017 The block SHALL have port busy_o, output, 1, meaning high when FSM is not IDLE.

Function
REQ-018 Address map SHALL be: 0..NUM_PORTS-1 PORT_ADDR[i] RW; NUM_PORTS CTRL RW; NUM_PORTS+1 VERSION RO; all others unmapped.
REQ-019 FSM states SHALL be IDLE, WAIT, ACK, RELEASE.
REQ-020 In IDLE with mem_sel_en=1 the block SHALL capture addr/data/wr_rd_s and go to WAIT (ACK_LAT>1) or ACK (ACK_LAT=1).
REQ-021 WAIT SHALL count ACK_LAT-1 cycles, then go to ACK; inputs in WAIT are ignored.
REQ-022 In ACK, mem_ack SHALL be 1 for exactly one cycle, i.e. ACK_LAT cycles after the accept edge.
REQ-023 A write to a RW register SHALL update it on the edge entering ACK; outputs reflect it in the ACK cycle.
REQ-024 A read SHALL drive mem_rd_data with the register value in the ACK cycle; otherwise mem_rd_data SHALL be 0.
REQ-025 Unmapped address or write to VERSION SHALL give mem_err=1 with mem_ack, no register change, mem_rd_data=0.
REQ-026 After ACK, state SHALL be RELEASE until mem_sel_en=0, then IDLE; a held request never executes twice.
REQ-027 With mem_sel_en=0 already in the ACK cycle, the FSM SHALL still pass through RELEASE for one cycle.
REQ-028 mem_ack and mem_err SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, PORT_ADDR[i]=0, CTRL=0, mem_ack=0, mem_err=0, mem_rd_data=0, busy_o=0.
REQ-030 Reset mid-transaction SHALL abort it: no ack, no register write.
REQ-031 The first request SHALL be accepted on the first rising edge with rst=0 and mem_sel_en=1.

Structure
REQ-032 Package cfg_reg_pkg SHALL hold the FSM state enum, CTRL_OFS/VERSION_OFS offset functions of NUM_PORTS, and reset constants.
REQ-033 The WAIT count SHALL be a sub-module lat_counter (load ACK_LAT-1, decrement, done flag).

Verification
REQ-034 NUM_PORTS=4, ACK_LAT=2: write 8'hA5 to addr 2 -> mem_ack 2 cycles after accept, mem_err=0, port_addr_o[23:16]=8'hA5.
REQ-035 Read addr 5 -> mem_rd_data=8'h01, mem_err=0; write 8'h55 to addr 5 -> mem_err=1, readback still 8'h01.
REQ-036 Read addr 8'h20 -> mem_ack with mem_err=1, mem_rd_data=0.
REQ-037 Write 8'h01 to addr 4, mem_sel_en held high 6 cycles -> exactly one mem_ack, cfg_en_o=1, busy_o high until sel_en drops.
REQ-038 Assert rst in WAIT of a write of 8'hFF to addr 0 -> no mem_ack, port_addr_o[7:0]=0, busy_o=0 immediately.
REQ-039 Back-to-back reads addr 0..3 with one idle cycle between -> four acks, each accept exactly one cycle after RELEASE exit.
